eth_tx_frame_arb: RTL



---
 rtl/eth_tx_arb_pkg.sv | 17 +
 rtl/eth_rr_arbiter.sv | 63 ++++++
 rtl/eth_tx_frame_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared state type and field widths for the Ethernet TX frame arbiter
// Contents:
//   arb_state_e  : IDLE (0), HDR (1), PAYLOAD (2)
//   ETH_MAC_W    : MAC address width
//   ETH_TYPE_W   : ethertype width
package eth_tx_arb_pkg;

   localparam int ETH_MAC_W  = 48;
   localparam int ETH_TYPE_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/eth_rr_arbiter.sv
// rtl/eth_rr_arbiter.sv - combinational request picker (round-robin, or fixed priority)
// Build option: ETH_TX_ARB_FIXED_PRIO_EN selects lowest-index-wins; otherwise round-robin.
// Ports:
//   req_i         : one request bit per source
//   last_i        : index of the most recently completed grant (round-robin origin)
//   grant_valid_o : at least one request present
//   grant_oh_o    : one-hot winner (all zero when no request)
//   grant_idx_o   : binary winner index (zero when no request)
module eth_rr_arbiter #(
   parameter int S_COUNT   = 2,
   parameter int SEL_WIDTH = 1
) (
   input  logic [S_COUNT-1:0]   req_i,
   input  logic [SEL_WIDTH-1:0] last_i,
   output logic                 grant_valid_o,
   output logic [S_COUNT-1:0]   grant_oh_o,
   output logic [SEL_WIDTH-1:0] grant_idx_o
);

`ifdef ETH_TX_ARB_FIXED_PRIO_EN

   // The last-grant pointer has no meaning under fixed priority.
   logic unused_last;
   assign unused_last = ^last_i;

   // Scan from the top down so the lowest asserted index is the final write.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_oh_o    = '0;
      grant_idx_o   = '0;
      for (int i = S_COUNT - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            grant_valid_o = 1'b1;
            grant_oh_o    = '0;
            grant_oh_o[i] = 1'b1;
            grant_idx_o   = SEL_WIDTH'(i);
         end
      end
   end

`else

   // Search starts one past the last winner and wraps, so the last winner
   // has the lowest priority in this round.
   always_comb begin
      int idx;
      grant_valid_o = 1'b0;
      grant_oh_o    = '0;
      grant_idx_o   = '0;
      idx           = 0;
      for (int k = 1; k <= S_COUNT; k++) begin
         idx = (int'(last_i) + k) % S_COUNT;
         if (!grant_valid_o && req_i[idx]) begin
            grant_valid_o   = 1'b1;
            grant_oh_o[idx] = 1'b1;
            grant_idx_o     = SEL_WIDTH'(idx);
         end
      end
   end

`endif

endmodule

// File: rtl/eth_tx_frame_arb.sv
// rtl/eth_tx_frame_arb.sv - frame-granular arbiter sharing one Ethernet frame transmitter
// Build option: ETH_TX_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   s_eth_hdr_*                    : per-source header handshake and fields (flattened, source i at [i*W +: W])
//   s_eth_payload_axis_*           : per-source payload streams (flattened)
//   m_eth_hdr_*                    : registered header towards the transmitter
//   m_eth_payload_axis_*           : payload of the granted source, zero outside PAYLOAD
//   grant_index                    : current or last granted source
//   busy                           : high while a frame is in progress (HDR or PAYLOAD)
module eth_tx_frame_arb
   import eth_tx_arb_pkg::*;
#(
   parameter int S_COUNT    = 2,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int SEL_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,

   input  logic [S_COUNT-1:0]               s_eth_hdr_valid,
   output logic [S_COUNT-1:0]               s_eth_hdr_ready,
   input  logic [S_COUNT*ETH_MAC_W-1:0]     s_eth_dest_mac,
   input  logic [S_COUNT*ETH_MAC_W-1:0]     s_eth_src_mac,
   input  logic [S_COUNT*ETH_TYPE_W-1:0]    s_eth_type,
   input  logic [S_COUNT*DATA_WIDTH-1:0]    s_eth_payload_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_eth_payload_axis_tkeep,
   input  logic [S_COUNT-1:0]               s_eth_payload_axis_tvalid,
   output logic [S_COUNT-1:0]               s_eth_payload_axis_tready,
   input  logic [S_COUNT-1:0]               s_eth_payload_axis_tlast,
   input  logic [S_COUNT-1:0]               s_eth_payload_axis_tuser,

   output logic                             m_eth_hdr_valid,
   input  logic                             m_eth_hdr_ready,
   output logic [ETH_MAC_W-1:0]             m_eth_dest_mac,
   output logic [ETH_MAC_W-1:0]             m_eth_src_mac,
   output logic [ETH_TYPE_W-1:0]            m_eth_type,
   output logic [DATA_WIDTH-1:0]            m_eth_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_eth_payload_axis_tkeep,
   output logic                             m_eth_payload_axis_tvalid,
   input  logic                             m_eth_payload_axis_tready,
   output logic                             m_eth_payload_axis_tlast,
   output logic                             m_eth_payload_axis_tuser,

   output logic [SEL_WIDTH-1:0]             grant_index,
   output logic                             busy
);

   arb_state_e                 state_q, state_d;
   logic [SEL_WIDTH-1:0]       grant_q, grant_d;
   logic [SEL_WIDTH-1:0]       rr_q, rr_d;
   logic [ETH_MAC_W-1:0]       dest_q, dest_d;
   logic [ETH_MAC_W-1:0]       smac_q, smac_d;
   logic [ETH_TYPE_W-1:0]      type_q, type_d;
   logic                       hdr_valid_q, hdr_valid_d;

   logic                       arb_valid;
   logic [S_COUNT-1:0]         arb_oh;
   logic [SEL_WIDTH-1:0]       arb_idx;

   logic [DATA_WIDTH-1:0]      sel_tdata;
   logic [KEEP_WIDTH-1:0]      sel_tkeep;
   logic                       sel_tvalid;
   logic                       sel_tlast;
   logic                       sel_tuser;
   logic                       in_payload;

   eth_rr_arbiter #(
      .S_COUNT   (S_COUNT),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_arb (
      .req_i         (s_eth_hdr_valid),
      .last_i        (rr_q),
      .grant_valid_o (arb_valid),
      .grant_oh_o    (arb_oh),
      .grant_idx_o   (arb_idx)
   );

   // Payload of the granted source; only meaningful while in PAYLOAD.
   assign sel_tdata  = s_eth_payload_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_tkeep  = s_eth_payload_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
   assign sel_tvalid = s_eth_payload_axis_tvalid[grant_q];
   assign sel_tlast  = s_eth_payload_axis_tlast[grant_q];
   assign sel_tuser  = s_eth_payload_axis_tuser[grant_q];
   assign in_payload = (state_q == PAYLOAD);

   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      rr_d            = rr_q;
      dest_d          = dest_q;
      smac_d          = smac_q;
      type_d          = type_q;
      hdr_valid_d     = hdr_valid_q;
      s_eth_hdr_ready = '0;

      case (state_q)
         IDLE: begin
            // The winner is acknowledged in the same cycle its header is captured.
            s_eth_hdr_ready = arb_oh;
            if (arb_valid) begin
               dest_d      = s_eth_dest_mac[int'(arb_idx)*ETH_MAC_W +: ETH_MAC_W];
               smac_d      = s_eth_src_mac[int'(arb_idx)*ETH_MAC_W +: ETH_MAC_W];
               type_d      = s_eth_type[int'(arb_idx)*ETH_TYPE_W +: ETH_TYPE_W];
               grant_d     = arb_idx;
               hdr_valid_d = 1'b1;
               state_d     = HDR;
            end
         end
         HDR: begin
            if (m_eth_hdr_ready) begin
               hdr_valid_d = 1'b0;
               state_d     = PAYLOAD;
            end
         end
         PAYLOAD: begin
            // The round-robin origin only moves once the frame has fully left.
            if (sel_tvalid && m_eth_payload_axis_tready && sel_tlast) begin
               rr_d    = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_eth_payload_axis_tready = '0;
      m_eth_payload_axis_tdata  = '0;
      m_eth_payload_axis_tkeep  = '0;
      m_eth_payload_axis_tvalid = 1'b0;
      m_eth_payload_axis_tlast  = 1'b0;
      m_eth_payload_axis_tuser  = 1'b0;
      if (in_payload) begin
         s_eth_payload_axis_tready[grant_q] = m_eth_payload_axis_tready;
         m_eth_payload_axis_tdata           = sel_tdata;
         m_eth_payload_axis_tkeep           = sel_tkeep;
         m_eth_payload_axis_tvalid          = sel_tvalid;
         m_eth_payload_axis_tlast           = sel_tlast;
         m_eth_payload_axis_tuser           = sel_tuser;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_q        <= SEL_WIDTH'(S_COUNT - 1);
         dest_q      <= '0;
         smac_q      <= '0;
         type_q      <= '0;
         hdr_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         dest_q      <= dest_d;
         smac_q      <= smac_d;
         type_q      <= type_d;
         hdr_valid_q <= hdr_valid_d;
      end
   end

   assign m_eth_hdr_valid = hdr_valid_q;
   assign m_eth_dest_mac  = dest_q;
   assign m_eth_src_mac   = smac_q;
   assign m_eth_type      = type_q;
   assign grant_index     = grant_q;
   assign busy            = (state_q != IDLE);

endmodule
